// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: state encoding, default
// geometry/latency and the byte-lane expansion helper.
package dmem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LATENCY     = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] lane_bits(input logic [3:0] mask);
    logic [DATA_W-1:0] bits;
    bits = '0;
    for (int b = 0; b < 4; b++) begin
      bits[8*b +: 8] = {8{mask[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    // Read and write never target the same request, so ordering is moot here.
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request, answers it
// after a fixed latency and holds the response until the pipeline takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_mask,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int              AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0]     ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_LOAD  = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              vld_p1;
  logic              rd_sel_p1;
  logic              err_p1;
  logic [DATA_W-1:0] lanes_p1;
  logic [DATA_W-1:0] ram_q;

  logic accept;
  logic addr_oob;
  logic illegal;
  logic do_wr;
  logic do_rd;

  assign o_req_ready = (state == ST_IDLE);
  assign accept      = i_req_valid & o_req_ready & ~i_rst;
  assign addr_oob    = ({1'b0, i_req_addr} >= ADDR_LIMIT);
  assign illegal     = (i_req_ren & i_req_wen) | addr_oob;
  assign do_wr       = accept & i_req_wen & ~illegal;
  assign do_rd       = accept & i_req_ren & ~illegal;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk   (i_clk),
    .addr  (i_req_addr[2 +: AW]),
    .we    (do_wr ? i_req_mask : 4'b0000),
    .wdata (i_req_wdata),
    .re    (do_rd),
    .rdata (ram_q)
  );

  // Accept stage: request qualifiers captured alongside the RAM read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      vld_p1    <= 1'b0;
      rd_sel_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_sel_p1 <= do_rd;
            err_p1    <= illegal;
            if (LATENCY == 1) begin
              state  <= ST_RESP;
              vld_p1 <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state  <= ST_RESP;
            vld_p1 <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            state  <= ST_IDLE;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      lanes_p1 <= lane_bits(i_req_mask);
    end
  end

  // Response stage: RAM output only changes on an accepted read, so it is stable in RESP.
  assign o_rsp_valid = vld_p1;
  assign o_rsp_err   = vld_p1 & err_p1;
  assign o_rsp_rdata = (vld_p1 & rd_sel_p1) ? (ram_q & lanes_p1) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a transaction-level
// memory model, plus accept-to-response latency tracking for LATENCY 2, 1 and 15.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int WIN   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_mask = '0;
  logic        req_ren = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  logic [2:0]  rdy_v;
  logic [2:0]  vld_v;
  logic [31:0] unused_rdata_l1, unused_rdata_l15;
  logic        unused_err_l1, unused_err_l15;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(req_addr), .i_req_mask(req_mask), .i_req_ren(req_ren), .i_req_wen(req_wen),
    .i_req_wdata(req_wdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy_v[1]),
    .i_req_addr(req_addr), .i_req_mask(req_mask), .i_req_ren(req_ren), .i_req_wen(req_wen),
    .i_req_wdata(req_wdata), .o_rsp_valid(vld_v[1]), .i_rsp_ready(1'b1),
    .o_rsp_rdata(unused_rdata_l1), .o_rsp_err(unused_err_l1));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) dut_l15 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy_v[2]),
    .i_req_addr(req_addr), .i_req_mask(req_mask), .i_req_ren(req_ren), .i_req_wen(req_wen),
    .i_req_wdata(req_wdata), .o_rsp_valid(vld_v[2]), .i_rsp_ready(1'b1),
    .o_rsp_rdata(unused_rdata_l15), .o_rsp_err(unused_err_l15));

  assign rdy_v[0] = o_req_ready;
  assign vld_v[0] = o_rsp_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT : (k == 1) ? 1 : 15;
  endfunction

  // Transaction-level model: one request in flight, answered LAT cycles later.
  logic        m_busy;
  int          m_age;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] mem_m [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        if ((req_ren && req_wen) || req_addr >= 32'(DEPTH * 4)) begin
          m_err   <= 1'b1;
          m_rdata <= '0;
        end else begin
          m_err   <= 1'b0;
          m_rdata <= req_ren ? (mem_m[req_addr[11:2]] & expand(req_mask)) : 32'h0;
          if (req_wen)
            mem_m[req_addr[11:2]] <= (mem_m[req_addr[11:2]] & ~expand(req_mask)) |
                                     (req_wdata & expand(req_mask));
        end
      end
    end else if (m_age >= LAT - 1 && rsp_ready) begin
      m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("req_ready", 32'(o_req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(m_busy && m_age >= LAT - 1));
      if (m_busy && m_age >= LAT - 1) begin
        chk("rsp_rdata", o_rsp_rdata, m_rdata);
        chk("rsp_err", 32'(o_rsp_err), 32'(m_err));
      end
    end
  end

  // Accept-to-valid distance for every instance, measured in whole cycles.
  int         cyc;
  int         acc_cyc [3];
  bit         pend [3];
  logic [2:0] vld_prev;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    vld_prev <= vld_v;
    for (int k = 0; k < 3; k++) begin
      if (!run) begin
        pend[k] <= 1'b0;
      end else begin
        if (vld_v[k] && !vld_prev[k]) begin
          chk($sformatf("latency_%0d", lat_of(k)), pend[k] ? 32'(cyc - acc_cyc[k]) : 32'hFFFF_FFFF,
              32'(lat_of(k)));
          pend[k] <= 1'b0;
        end
        if (rst) begin
          pend[k] <= 1'b0;
        end else if (req_valid && rdy_v[k]) begin
          pend[k]    <= 1'b1;
          acc_cyc[k] <= cyc;
        end
      end
    end
  end

  task automatic txn(input logic [31:0] a, input logic [3:0] m, input logic r, input logic w,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    rd = '0; e = 1'b0; lat = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_mask = m; req_ren = r; req_wen = w; req_wdata = wd;
    rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin chk("accept_timeout", 32'(n), 32'd0); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_mask = 4'($urandom); req_ren = 1'($urandom);
    req_wen = 1'($urandom); req_wdata = $urandom;
    lat = 1;
    @(negedge clk);
    while (!o_rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (lat >= 40) begin chk("rsp_timeout", 32'(lat), 32'(LAT)); return; end
    for (int i = 0; i < hold; i++) @(negedge clk);
    rd = o_rsp_rdata; e = o_rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) begin
      a = $urandom;
      if (a < 32'h1000) a = a + 32'h1000;
    end else begin
      a = 32'($urandom_range(0, WIN - 1)) * 32'd4 + 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          op;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(o_req_ready), 32'd1);
    chk("reset_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_rdata", o_rsp_rdata, 32'd0);
    chk("reset_err", 32'(o_rsp_err), 32'd0);

    for (int i = 0; i < WIN; i++)
      txn(32'(i * 4), 4'hF, 1'b0, 1'b1, {8'(i), 8'hA5, 8'(i), 8'h5A}, 0, rd, e, lat);

    txn(32'h10, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF, 0, rd, e, lat);
    chk("wr_rdata", rd, 32'h0); chk("wr_err", 32'(e), 32'd0); chk("wr_latency", 32'(lat), 32'd2);
    txn(32'h10, 4'hF, 1'b1, 1'b0, 32'h0, 0, rd, e, lat);
    chk("rd_full", rd, 32'hDEADBEEF);
    txn(32'h10, 4'b0100, 1'b0, 1'b1, 32'h00AA0000, 0, rd, e, lat);
    chk("bytewr_rdata", rd, 32'h0);
    txn(32'h10, 4'hF, 1'b1, 1'b0, 32'h0, 0, rd, e, lat);
    chk("rd_after_byte", rd, 32'hDEAABEEF);
    txn(32'h12, 4'b0011, 1'b1, 1'b0, 32'h0, 0, rd, e, lat);
    chk("rd_mask_0011", rd, 32'h0000BEEF);
    txn(32'h10, 4'b0000, 1'b1, 1'b0, 32'h0, 0, rd, e, lat);
    chk("rd_mask_0", rd, 32'h0);

    txn(32'h10, 4'hF, 1'b1, 1'b1, 32'h0, 0, rd, e, lat);
    chk("both_err", 32'(e), 32'd1); chk("both_rdata", rd, 32'h0);
    txn(32'h1000, 4'hF, 1'b0, 1'b1, 32'hFFFFFFFF, 0, rd, e, lat);
    chk("oob_err", 32'(e), 32'd1);
    txn(32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 0, rd, e, lat);
    chk("oob_no_alias", rd, 32'h00A5005A);
    txn(32'h10, 4'hF, 1'b1, 1'b0, 32'h0, 0, rd, e, lat);
    chk("illegal_no_update", rd, 32'hDEAABEEF);
    txn(32'h14, 4'hF, 1'b0, 1'b0, 32'h0, 0, rd, e, lat);
    chk("nop_rdata", rd, 32'h0); chk("nop_err", 32'(e), 32'd0);

    txn(32'h10, 4'hF, 1'b1, 1'b0, 32'h0, 5, rd, e, lat);
    chk("backpressure_rdata", rd, 32'hDEAABEEF);

    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h20; req_mask = 4'hF; req_ren = 1'b0; req_wen = 1'b1;
    req_wdata = 32'h12345678;
    @(negedge clk);
    chk("pre_wait_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(o_req_ready), 32'd1);
    chk("post_rst_valid", 32'(o_rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    txn(32'h20, 4'hF, 1'b1, 1'b0, 32'h0, 0, rd, e, lat);
    chk("rd_after_rst", rd, 32'h12345678);

    repeat (3000) begin
      @(posedge clk); #1;
      op = $urandom_range(0, 7);
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = rand_addr();
      req_mask  = 4'($urandom);
      req_wdata = $urandom;
      req_ren   = (op <= 2) || (op == 6);
      req_wen   = (op >= 3 && op <= 6);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end

    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1; rst = 1'b0;
    repeat (25) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
